fib_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter sitting directly downstream of the `fib` stage. It accepts an unsigned binary word using the same strobe/busy handshake as `fib`, typically `o_fib` captured on the falling edge of `fib`'s `o_busy`. It converts the word with a shift-and-add-3 (double-dabble) loop, one bit per clock. The packed BCD digits feed the display/UART formatting stage.

---
 rtl/fib_bcd_conv_pkg.sv | 12 +
 rtl/fib_bcd_conv_if.sv | 26 ++
 rtl/fib_bcd_conv_digit_adj.sv | 14 +
 rtl/fib_bcd_conv.sv | 82 ++++++++
 tb/tb_fib_bcd_conv.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fib_bcd_conv_pkg.sv
// Shared constants and state encodings for the fib -> BCD conversion stage.
// WIDTH default matches the upstream fib instance.
package fib_bcd_conv_pkg;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DIGITS = 10;
  localparam int BCD_DIGIT_W    = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;
endpackage

// File: rtl/fib_bcd_conv_if.sv
// Strobe/busy handshake bundle between the fib stage (master) and the BCD converter (slave).
interface fib_bcd_conv_if
  import fib_bcd_conv_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
);
  // Handshake: i_stb is sampled on a rising edge only while o_busy is low, and that
  // edge also captures i_bin. o_valid is a single-cycle pulse that coincides with
  // o_busy falling and with o_bcd taking the new result; o_bcd holds otherwise.
  logic                          i_stb;
  logic                          o_busy;
  logic [WIDTH-1:0]              i_bin;
  logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd;
  logic                          o_valid;

  modport master (
    output i_stb, i_bin,
    input  o_busy, o_bcd, o_valid
  );

  modport slave (
    input  i_stb, i_bin,
    output o_busy, o_bcd, o_valid
  );
endinterface

// File: rtl/fib_bcd_conv_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is shifted.
module bcd_digit_adj
  import fib_bcd_conv_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end
  end
endmodule

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per clock,
// WIDTH cycles from accept to result.
module fib_bcd_conv
  import fib_bcd_conv_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
)(
  input  logic            i_clk,
  input  logic            i_reset_n,
  fib_bcd_conv_if.slave   bus,
  output state_t          dbg_state_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    scratch_q;
  logic [BW-1:0]    bcd_q;
  logic             valid_q;
  logic             busy_q;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_d;
  logic [WIDTH-1:0] shift_d;

  // All digits are corrected from their pre-shift values in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The MSB of the top digit falls off, giving value mod 10^DIGITS when too narrow.
  assign scratch_d = {adj[BW-2:0], shift_q[WIDTH-1]};
  assign shift_d   = {shift_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_stb) begin
            shift_q   <= bus.i_bin;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_bcd   = bcd_q;
  assign bus.o_valid = valid_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fib_bcd_conv.sv
// Directed bench for fib_bcd_conv: hand-computed BCD results, handshake timing and reset abort.
module tb_fib_bcd_conv;
  import fib_bcd_conv_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     total;
  int     bad;
  int     n_busy;
  int     n_idle;
  bit     got;

  fib_bcd_conv_if #(.WIDTH(32), .DIGITS(10)) bus ();

  fib_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_valid is seen, counting busy negedges.
  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (bus.o_valid === 1'b1) seen = 1'b1;
      else begin
        if (bus.o_busy === 1'b1) busy_n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic start(input logic [31:0] v);
    bus.i_stb = 1'b1;
    bus.i_bin = v;
    @(negedge clk);
    bus.i_stb = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_stb = 1'b0;
    bus.i_bin = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {39'd0, bus.o_busy}, 40'd0);
    check("rst_valid", {39'd0, bus.o_valid}, 40'd0);
    check("rst_bcd", bus.o_bcd, 40'd0);
    check("rst_state", {39'd0, dbg_state}, {39'd0, ST_IDLE});
    rst_n = 1'b1;
    @(negedge clk);

    start(32'd0);
    check("zero_state", {39'd0, dbg_state}, {39'd0, ST_CONVERT});
    wait_done(n_busy, got);
    check("zero_got", {39'd0, got}, 40'd1);
    check("zero_bcd", bus.o_bcd, 40'd0);
    check("zero_busy_n", 40'(n_busy), 40'd32);
    @(negedge clk);

    start(32'd55);
    wait_done(n_busy, got);
    check("f10_got", {39'd0, got}, 40'd1);
    check("f10_busy_n", 40'(n_busy), 40'd32);
    check("f10_busy_fall", {39'd0, bus.o_busy}, 40'd0);
    check("f10_bcd", bus.o_bcd, 40'h55);
    @(negedge clk);
    check("f10_pulse", {39'd0, bus.o_valid}, 40'd0);
    check("f10_hold", bus.o_bcd, 40'h55);

    start(32'hFFFF_FFFF);
    wait_done(n_busy, got);
    check("max_got", {39'd0, got}, 40'd1);
    check("max_bcd", bus.o_bcd, 40'h4294967295);
    @(negedge clk);

    // Held strobe: back-to-back conversions with a single idle cycle between them.
    bus.i_stb = 1'b1;
    bus.i_bin = 32'd1;
    @(negedge clk);
    wait_done(n_busy, got);
    check("b2b1_got", {39'd0, got}, 40'd1);
    check("b2b1_bcd", bus.o_bcd, 40'h1);
    bus.i_bin = 32'd2;
    n_idle = 0;
    for (int k = 0; k < 10 && bus.o_busy !== 1'b1; k++) begin
      n_idle++;
      @(negedge clk);
    end
    bus.i_stb = 1'b0;
    check("b2b_idle", 40'(n_idle), 40'd1);
    repeat (10) @(negedge clk);
    bus.i_bin = 32'd99;
    wait_done(n_busy, got);
    check("b2b2_got", {39'd0, got}, 40'd1);
    check("b2b2_bcd", bus.o_bcd, 40'h2);
    @(negedge clk);

    // A strobe while busy must be dropped, not queued.
    start(32'd7);
    repeat (5) @(negedge clk);
    start(32'd9);
    wait_done(n_busy, got);
    check("drop_got", {39'd0, got}, 40'd1);
    check("drop_bcd", bus.o_bcd, 40'h7);
    repeat (3) @(negedge clk);
    check("drop_idle", {39'd0, bus.o_busy}, 40'd0);
    check("drop_hold", bus.o_bcd, 40'h7);

    // Asynchronous reset in the middle of a conversion.
    start(32'd123);
    repeat (9) @(negedge clk);
    check("abort_busy_pre", {39'd0, bus.o_busy}, 40'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {39'd0, bus.o_busy}, 40'd0);
    check("abort_bcd", bus.o_bcd, 40'd0);
    check("abort_state", {39'd0, dbg_state}, {39'd0, ST_IDLE});
    bus.i_stb = 1'b1;
    bus.i_bin = 32'd123;
    repeat (2) @(negedge clk);
    check("abort_valid", {39'd0, bus.o_valid}, 40'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_stb = 1'b0;
    check("rel_busy", {39'd0, bus.o_busy}, 40'd1);
    wait_done(n_busy, got);
    check("rel_got", {39'd0, got}, 40'd1);
    check("rel_busy_n", 40'(n_busy), 40'd32);
    check("rel_bcd", bus.o_bcd, 40'h123);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
